// File: rtl/ext_irq_router_pkg.sv
// Shared types and constants for the external interrupt router: gateway state
// encodings, the "no source" ID, hart ID width and default sizing.
package ext_irq_router_pkg;

  localparam int HART_ID_W    = 2;
  localparam int DEF_N_SRC    = 8;
  localparam int DEF_N_HART   = 4;
  localparam int IRQ_SRC_NONE = 0;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE  = 2'd0,
    IRQ_ST_PEND  = 2'd1,
    IRQ_ST_INSVC = 2'd2
  } irq_state_e;

  // Advance a round-robin position by one, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ext_irq_router_gateway.sv
// One interrupt source: IDLE/PEND/INSVC state machine plus its enable, routing
// target and the hart that currently owns it while in service.
module ext_irq_router_gateway
  import ext_irq_router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 irq,
  input  logic                 cfg_hit,
  input  logic                 cfg_en,
  input  logic [HART_ID_W-1:0] cfg_target,
  input  logic                 grant,
  input  logic [HART_ID_W-1:0] grant_hart,
  input  logic                 cpl_hit,
  input  logic [HART_ID_W-1:0] cpl_hart,
  output logic                 pend,
  output logic [HART_ID_W-1:0] target
);

  irq_state_e           state_q, state_d;
  logic                 en_q, en_d;
  logic [HART_ID_W-1:0] target_q, target_d;
  logic [HART_ID_W-1:0] owner_q, owner_d;

  // NOTE: every signal gets its hold value before any branch, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    target_d = target_q;
    owner_d  = owner_q;

    if (cfg_hit) begin
      en_d     = cfg_en;
      target_d = cfg_target;
    end

    case (state_q)
      IRQ_ST_IDLE: begin
        if (irq && en_q) state_d = IRQ_ST_PEND;
      end
      IRQ_ST_PEND: begin
        // A grant wins over a same-cycle disable: the claim saw the old enable.
        if (grant) begin
          state_d = IRQ_ST_INSVC;
          owner_d = grant_hart;
        end else if (cfg_hit && !cfg_en) begin
          state_d = IRQ_ST_IDLE;
        end
      end
      IRQ_ST_INSVC: begin
        if (cpl_hit && (cpl_hart == owner_q)) state_d = IRQ_ST_IDLE;
      end
      default: state_d = IRQ_ST_IDLE;
    endcase
  end

  // NOTE: state registers use <= so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IRQ_ST_IDLE;
      en_q     <= 1'b0;
      target_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      target_q <= target_d;
      owner_q  <= owner_d;
    end
  end

  assign pend   = (state_q == IRQ_ST_PEND);
  assign target = target_q;

endmodule

// File: rtl/ext_irq_router.sv
// Routes level interrupt sources to per-hart MEIP bits with claim/complete
// sequencing and a per-hart round-robin claim arbiter.
module ext_irq_router
  import ext_irq_router_pkg::*;
#(
  parameter  int N_SRC    = DEF_N_SRC,
  parameter  int N_HART   = DEF_N_HART,
  localparam int SRC_ID_W = $clog2(N_SRC + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     irq_src,
  input  logic                 cfg_we,
  input  logic [SRC_ID_W-1:0]  cfg_src_id,
  input  logic                 cfg_en,
  input  logic [HART_ID_W-1:0] cfg_target,
  input  logic                 claim_req,
  input  logic [HART_ID_W-1:0] claim_hart_id,
  output logic                 claim_ack,
  output logic [SRC_ID_W-1:0]  claim_src_id,
  input  logic                 complete_req,
  input  logic [HART_ID_W-1:0] complete_hart_id,
  input  logic [SRC_ID_W-1:0]  complete_src_id,
  output logic [N_HART-1:0]    meip
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]     src_pend;
  logic [HART_ID_W-1:0] src_target [N_SRC];
  logic [N_SRC-1:0]     grant;
  logic [N_SRC-1:0]     cand;

  logic [PTR_W-1:0]     rr_ptr_q [N_HART];
  logic [PTR_W-1:0]     rr_ptr_d [N_HART];
  logic [N_HART-1:0]    meip_q, meip_d;
  logic                 claim_ack_q, claim_ack_d;
  logic [SRC_ID_W-1:0]  claim_src_id_q, claim_src_id_d;

  logic                 hart_ok;
  logic                 found;
  logic [PTR_W-1:0]     ptr_sel;
  logic [PTR_W-1:0]     scan_idx;
  logic [PTR_W-1:0]     win_idx;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    ext_irq_router_gateway u_gw (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq        (irq_src[i]),
      .cfg_hit    (cfg_we && (cfg_src_id == SRC_ID_W'(i + 1))),
      .cfg_en     (cfg_en),
      .cfg_target (cfg_target),
      .grant      (grant[i]),
      .grant_hart (claim_hart_id),
      .cpl_hit    (complete_req && (complete_src_id == SRC_ID_W'(i + 1))),
      .cpl_hart   (complete_hart_id),
      .pend       (src_pend[i]),
      .target     (src_target[i])
    );
  end

  // Rotate-priority find-first over this hart's pending sources, starting at its pointer.
  always_comb begin
    hart_ok = (int'(claim_hart_id) < N_HART);
    ptr_sel = '0;
    if (hart_ok) ptr_sel = rr_ptr_q[claim_hart_id];

    for (int i = 0; i < N_SRC; i++) begin
      cand[i] = hart_ok && src_pend[i] && (src_target[i] == claim_hart_id);
    end

    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = PTR_W'((int'(ptr_sel) + k) % N_SRC);
      if (!found && cand[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant          = '0;
    rr_ptr_d       = rr_ptr_q;
    claim_ack_d    = claim_req;
    claim_src_id_d = claim_src_id_q;

    if (claim_req) begin
      claim_src_id_d = SRC_ID_W'(IRQ_SRC_NONE);
      if (found) begin
        grant[win_idx]          = 1'b1;
        claim_src_id_d          = SRC_ID_W'(int'(win_idx) + 1);
        rr_ptr_d[claim_hart_id] = PTR_W'(wrap_inc(int'(win_idx), N_SRC));
      end
    end
  end

  always_comb begin
    for (int h = 0; h < N_HART; h++) begin
      meip_d[h] = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        if (src_pend[i] && (src_target[i] == HART_ID_W'(h))) meip_d[h] = 1'b1;
      end
    end
  end

  // NOTE: the pointer array is a handful of plain flops, not a RAM, so every entry is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < N_HART; h++) rr_ptr_q[h] <= '0;
      meip_q         <= '0;
      claim_ack_q    <= 1'b0;
      claim_src_id_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      meip_q         <= meip_d;
      claim_ack_q    <= claim_ack_d;
      claim_src_id_q <= claim_src_id_d;
    end
  end

  assign meip         = meip_q;
  assign claim_ack    = claim_ack_q;
  assign claim_src_id = claim_src_id_q;

endmodule

// File: tb/tb_ext_irq_router.sv
// Self-checking bench for ext_irq_router: claim results are scoreboarded through
// a queue; MEIP timing and hold behaviour are checked inline by each scenario.
module tb_ext_irq_router;
  import ext_irq_router_pkg::*;

  localparam int N_SRC    = 8;
  localparam int N_HART   = 4;
  localparam int SRC_ID_W = $clog2(N_SRC + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [N_SRC-1:0]     irq_src = '0;
  logic                 cfg_we = 1'b0;
  logic [SRC_ID_W-1:0]  cfg_src_id = '0;
  logic                 cfg_en = 1'b0;
  logic [HART_ID_W-1:0] cfg_target = '0;
  logic                 claim_req = 1'b0;
  logic [HART_ID_W-1:0] claim_hart_id = '0;
  logic                 claim_ack;
  logic [SRC_ID_W-1:0]  claim_src_id;
  logic                 complete_req = 1'b0;
  logic [HART_ID_W-1:0] complete_hart_id = '0;
  logic [SRC_ID_W-1:0]  complete_src_id = '0;
  logic [N_HART-1:0]    meip;

  int checks   = 0;
  int failures = 0;
  logic [SRC_ID_W-1:0] exp_q [$];

  ext_irq_router #(.N_SRC(N_SRC), .N_HART(N_HART)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq_src          (irq_src),
    .cfg_we           (cfg_we),
    .cfg_src_id       (cfg_src_id),
    .cfg_en           (cfg_en),
    .cfg_target       (cfg_target),
    .claim_req        (claim_req),
    .claim_hart_id    (claim_hart_id),
    .claim_ack        (claim_ack),
    .claim_src_id     (claim_src_id),
    .complete_req     (complete_req),
    .complete_hart_id (complete_hart_id),
    .complete_src_id  (complete_src_id),
    .meip             (meip)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every ack pops the oldest expected claim result.
  always @(negedge clk) begin
    if (rst_n && claim_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL claim_unexpected: ack with id %0d, wanted no ack", claim_src_id);
      end else begin
        logic [SRC_ID_W-1:0] want;
        want = exp_q.pop_front();
        if (claim_src_id !== want) begin
          failures++;
          $display("FAIL claim_id: got %0d want %0d", claim_src_id, want);
        end
      end
    end
  end

  // All drive tasks start just after a falling edge and return one cycle later.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_cfg(input int src, input bit en, input int tgt);
    cfg_we = 1'b1; cfg_src_id = SRC_ID_W'(src); cfg_en = en; cfg_target = HART_ID_W'(tgt);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_claim(input int hart, input int want);
    exp_q.push_back(SRC_ID_W'(want));
    claim_req = 1'b1; claim_hart_id = HART_ID_W'(hart);
    @(negedge clk);
    claim_req = 1'b0;
  endtask

  task automatic do_complete(input int hart, input int src);
    complete_req = 1'b1; complete_hart_id = HART_ID_W'(hart); complete_src_id = SRC_ID_W'(src);
    @(negedge clk);
    complete_req = 1'b0;
  endtask

  task automatic wait_acks(input string name);
    int budget;
    budget = 8;
    #1;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_acks: %0d claims unanswered, want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_meip(input string name, input logic [N_HART-1:0] want);
    checks++;
    if (meip !== want) begin
      failures++;
      $display("FAIL %s: meip got %b want %b", name, meip, want);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_meip("reset_meip", 4'b0000);
    checks++;
    if (claim_ack !== 1'b0 || claim_src_id !== '0) begin
      failures++;
      $display("FAIL reset_claim: ack %b id %0d want 0 0", claim_ack, claim_src_id);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_route();
    do_cfg(3, 1'b1, 2);
    irq_src[2] = 1'b1;
    tick(1);
    chk_meip("route_latency", 4'b0000);
    tick(1);
    chk_meip("route_meip", 4'b0100);
    do_claim(2, 3);
    irq_src[2] = 1'b0;
    tick(1);
    chk_meip("route_claimed", 4'b0000);
    do_complete(2, 3);
    do_cfg(3, 1'b0, 0);
    wait_acks("route");
  endtask

  task automatic test_fairness();
    int order [4] = '{1, 2, 5, 1};
    do_cfg(1, 1'b1, 0);
    do_cfg(2, 1'b1, 0);
    do_cfg(5, 1'b1, 0);
    irq_src[0] = 1'b1; irq_src[1] = 1'b1; irq_src[4] = 1'b1;
    tick(2);
    chk_meip("fair_pend", 4'b0001);
    foreach (order[j]) begin
      do_claim(0, order[j]);
      chk_meip("fair_meip_claim", 4'b0001);
      do_complete(0, order[j]);
      chk_meip("fair_meip_cpl", 4'b0001);
      tick(2);
    end
    irq_src = '0;
    do_cfg(1, 1'b0, 0);
    do_cfg(2, 1'b0, 0);
    do_cfg(5, 1'b0, 0);
    tick(1);
    chk_meip("fair_cleanup", 4'b0000);
    wait_acks("fair");
  endtask

  task automatic test_empty_claim();
    do_cfg(2, 1'b1, 1);
    do_cfg(7, 1'b1, 1);
    irq_src[1] = 1'b1; irq_src[6] = 1'b1;
    tick(2);
    do_claim(1, 2);
    irq_src[1] = 1'b0;
    do_complete(1, 2);
    do_claim(1, 7);
    irq_src[6] = 1'b0;
    do_complete(1, 7);
    // Hart 1 pointer now sits at position 7; an empty claim must leave it there.
    do_claim(1, 0);
    tick(1);
    checks++;
    if (claim_ack !== 1'b0 || claim_src_id !== SRC_ID_W'(0)) begin
      failures++;
      $display("FAIL empty_hold: ack %b id %0d want 0 0", claim_ack, claim_src_id);
    end
    do_cfg(8, 1'b1, 1);
    irq_src[1] = 1'b1; irq_src[7] = 1'b1;
    tick(2);
    do_claim(1, 8);
    tick(1);
    checks++;
    if (claim_ack !== 1'b0 || claim_src_id !== SRC_ID_W'(8)) begin
      failures++;
      $display("FAIL claim_hold: ack %b id %0d want 0 8", claim_ack, claim_src_id);
    end
    do_claim(1, 2);
    irq_src = '0;
    do_complete(1, 8);
    do_complete(1, 2);
    do_cfg(2, 1'b0, 0);
    do_cfg(7, 1'b0, 0);
    do_cfg(8, 1'b0, 0);
    tick(1);
    chk_meip("empty_cleanup", 4'b0000);
    wait_acks("empty");
  endtask

  task automatic test_ownership();
    do_cfg(4, 1'b1, 0);
    irq_src[3] = 1'b1;
    tick(2);
    do_claim(0, 4);
    do_complete(1, 4);
    tick(3);
    chk_meip("own_wrong_hart", 4'b0000);
    do_complete(0, 4);
    chk_meip("own_cpl_edge", 4'b0000);
    tick(1);
    chk_meip("own_idle_edge", 4'b0000);
    tick(1);
    chk_meip("own_repend", 4'b0001);
    irq_src[3] = 1'b0;
    do_claim(0, 4);
    do_complete(0, 4);
    do_cfg(4, 1'b0, 0);
    wait_acks("own");
  endtask

  task automatic test_disable();
    do_cfg(6, 1'b1, 3);
    irq_src[5] = 1'b1;
    tick(2);
    chk_meip("dis_pend", 4'b1000);
    do_cfg(6, 1'b0, 3);
    chk_meip("dis_lag", 4'b1000);
    tick(1);
    chk_meip("dis_drop", 4'b0000);
    do_cfg(6, 1'b1, 3);
    tick(2);
    chk_meip("dis_reenable", 4'b1000);
    do_claim(3, 6);
    do_cfg(6, 1'b0, 3);
    do_cfg(6, 1'b1, 3);
    tick(3);
    chk_meip("dis_insvc", 4'b0000);
    do_complete(3, 6);
    tick(2);
    chk_meip("dis_cpl_repend", 4'b1000);
    irq_src[5] = 1'b0;
    do_claim(3, 6);
    do_complete(3, 6);
    do_cfg(6, 1'b0, 0);
    wait_acks("dis");
  endtask

  task automatic test_reset_mid();
    do_cfg(1, 1'b1, 0);
    do_cfg(2, 1'b1, 0);
    irq_src[0] = 1'b1; irq_src[1] = 1'b1;
    tick(2);
    do_claim(0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_meip("rst_mid_meip", 4'b0000);
    checks++;
    if (claim_ack !== 1'b0 || claim_src_id !== '0) begin
      failures++;
      $display("FAIL rst_mid_claim: ack %b id %0d want 0 0", claim_ack, claim_src_id);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    chk_meip("rst_quiet", 4'b0000);
    do_claim(0, 0);
    do_cfg(1, 1'b1, 0);
    do_cfg(2, 1'b1, 0);
    tick(2);
    chk_meip("rst_reenable", 4'b0001);
    do_claim(0, 1);
    irq_src = '0;
    do_complete(0, 1);
    do_claim(0, 2);
    do_complete(0, 2);
    do_cfg(1, 1'b0, 0);
    do_cfg(2, 1'b0, 0);
    wait_acks("rst");
  endtask

  initial begin
    test_reset();
    test_route();
    test_fairness();
    test_empty_claim();
    test_ownership();
    test_disable();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: %0d results outstanding, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
